// File: rtl/ndata_width_converter_if.sv
// Element-stream interface: per-lane data and keep plus packet last, valid/ready handshake.
interface ndata_i #(
    parameter type data_t = logic [7:0],
    parameter int  N      = 1
);
    data_t [N-1:0] data;
    logic  [N-1:0] keep;
    logic          last;
    logic          valid;
    logic          ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/ndata_width_converter.sv
// Re-lanes an ndata stream by an integer ratio (upsize, downsize or pass-through)
// with a registered output; keep is carried untouched, empty trailing slices of a last beat are dropped.
module ndata_width_converter #(
    parameter type data_t           = logic [7:0],
    parameter int  NUM_IN_ELEMENTS  = 8,
    parameter int  NUM_OUT_ELEMENTS = 4
) (
    input logic clk,
    input logic rst_n,
    ndata_i.s   in,
    ndata_i.m   out
);
    localparam int IN    = NUM_IN_ELEMENTS;
    localparam int OUT   = NUM_OUT_ELEMENTS;
    localparam int RATIO = (IN > OUT) ? IN / OUT : OUT / IN;

    if (RATIO * ((IN > OUT) ? OUT : IN) != ((IN > OUT) ? IN : OUT)) begin : g_bad_ratio
        $error("ndata_width_converter: lane counts must be integer multiples of each other");
    end

    if (IN == OUT) begin : g_equal
        data_t [OUT-1:0] q_data;
        logic  [OUT-1:0] q_keep;
        logic            q_last;
        logic            q_valid;

        assign in.ready  = !q_valid || out.ready;
        assign out.valid = q_valid;
        assign out.data  = q_data;
        assign out.keep  = q_keep;
        assign out.last  = q_last;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q_valid <= 1'b0;
                q_keep  <= '0;
                q_last  <= 1'b0;
            end else if (in.valid && in.ready) begin
                q_valid <= 1'b1;
                q_data  <= in.data;
                q_keep  <= in.keep;
                q_last  <= in.last;
            end else if (out.ready) begin
                q_valid <= 1'b0;
            end
        end
    end else if (OUT > IN) begin : g_up
        localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

        data_t [OUT-1:0] acc_data, q_data, nxt_data;
        logic  [OUT-1:0] acc_keep, q_keep, nxt_keep;
        logic  [CW-1:0]  cnt;
        logic            q_last, q_valid, take, emit;

        assign in.ready  = !q_valid || out.ready;
        assign take      = in.valid && in.ready;
        assign emit      = (cnt == CW'(RATIO - 1)) || in.last;
        assign out.valid = q_valid;
        assign out.data  = q_data;
        assign out.keep  = q_keep;
        assign out.last  = q_last;

        // Current beat merged into the accumulator; unfilled slots keep 0 since acc_keep clears on emit.
        always_comb begin
            nxt_data = acc_data;
            nxt_keep = acc_keep;
            nxt_data[cnt*IN +: IN] = in.data;
            nxt_keep[cnt*IN +: IN] = in.keep;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt      <= '0;
                acc_keep <= '0;
                q_valid  <= 1'b0;
                q_keep   <= '0;
                q_last   <= 1'b0;
            end else begin
                if (out.ready) q_valid <= 1'b0;
                if (take) begin
                    if (emit) begin
                        q_valid  <= 1'b1;
                        q_data   <= nxt_data;
                        q_keep   <= nxt_keep;
                        q_last   <= in.last;
                        cnt      <= '0;
                        acc_keep <= '0;
                    end else begin
                        acc_data <= nxt_data;
                        acc_keep <= nxt_keep;
                        cnt      <= cnt + 1'b1;
                    end
                end
            end
        end
    end else begin : g_down
        localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

        data_t [IN-1:0] h_data;
        logic  [IN-1:0] h_keep;
        logic           h_last, h_full;
        logic  [CW-1:0] s;
        logic           rest_empty, fin;

        // A last beat ends early once every lane past the current slice is empty.
        always_comb begin
            rest_empty = 1'b1;
            for (int j = 0; j < IN; j++)
                if (j >= (int'(s) + 1) * OUT && h_keep[j]) rest_empty = 1'b0;
        end

        assign fin       = (s == CW'(RATIO - 1)) || (h_last && rest_empty);
        assign in.ready  = !h_full || (out.ready && fin);
        assign out.valid = h_full;
        assign out.data  = h_data[s*OUT +: OUT];
        assign out.keep  = h_keep[s*OUT +: OUT];
        assign out.last  = h_last && fin;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                h_full <= 1'b0;
                h_keep <= '0;
                h_last <= 1'b0;
                s      <= '0;
            end else if (in.valid && in.ready) begin
                h_full <= 1'b1;
                h_data <= in.data;
                h_keep <= in.keep;
                h_last <= in.last;
                s      <= '0;
            end else if (h_full && out.ready) begin
                if (fin) h_full <= 1'b0;
                else     s      <= s + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ndata_width_converter.sv
// Directed vectors plus scoreboarded random traffic for upsize (2->8), downsize (8->2) and equal (4->4).
module tb_ndata_width_converter;
    typedef logic [7:0] elem_t;
    typedef struct packed { logic [63:0] d; logic [7:0] k; logic l; } beat_t;
    typedef struct { int m; beat_t b; beat_t e; } vec_t;

    localparam int UP = 0, DN = 1, EQ = 2;
    localparam int NPKT = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ndata_i #(.data_t(elem_t), .N(2)) up_in ();
    ndata_i #(.data_t(elem_t), .N(8)) up_out ();
    ndata_i #(.data_t(elem_t), .N(8)) dn_in ();
    ndata_i #(.data_t(elem_t), .N(2)) dn_out ();
    ndata_i #(.data_t(elem_t), .N(4)) eq_in ();
    ndata_i #(.data_t(elem_t), .N(4)) eq_out ();

    ndata_width_converter #(.data_t(elem_t), .NUM_IN_ELEMENTS(2), .NUM_OUT_ELEMENTS(8))
        u_up (.clk(clk), .rst_n(rst_n), .in(up_in), .out(up_out));
    ndata_width_converter #(.data_t(elem_t), .NUM_IN_ELEMENTS(8), .NUM_OUT_ELEMENTS(2))
        u_dn (.clk(clk), .rst_n(rst_n), .in(dn_in), .out(dn_out));
    ndata_width_converter #(.data_t(elem_t), .NUM_IN_ELEMENTS(4), .NUM_OUT_ELEMENTS(4))
        u_eq (.clk(clk), .rst_n(rst_n), .in(eq_in), .out(eq_out));

    int checks = 0;
    int failures = 0;
    beat_t in_q[$];
    beat_t exp_q[$];

    function automatic beat_t bt(logic [63:0] d, logic [7:0] k, logic l);
        beat_t r;
        r.d = d; r.k = k; r.l = l;
        return r;
    endfunction

    // Data under keep=0 is don't-care, so compare masked beats.
    function automatic beat_t msk(beat_t b);
        for (int i = 0; i < 8; i++) if (!b.k[i]) b.d[i*8 +: 8] = 8'h00;
        return b;
    endfunction

    task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(int m, beat_t b, logic v);
        case (m)
            UP: begin up_in.data = b.d[15:0]; up_in.keep = b.k[1:0]; up_in.last = b.l; up_in.valid = v; end
            DN: begin dn_in.data = b.d;       dn_in.keep = b.k;      dn_in.last = b.l; dn_in.valid = v; end
            default: begin eq_in.data = b.d[31:0]; eq_in.keep = b.k[3:0]; eq_in.last = b.l; eq_in.valid = v; end
        endcase
    endtask

    task automatic set_rdy(int m, logic r);
        case (m)
            UP: up_out.ready = r;
            DN: dn_out.ready = r;
            default: eq_out.ready = r;
        endcase
    endtask

    function automatic beat_t get_out(int m);
        beat_t r = '0;
        case (m)
            UP: begin r.d = up_out.data; r.k = up_out.keep; r.l = up_out.last; end
            DN: begin r.d[15:0] = dn_out.data; r.k[1:0] = dn_out.keep; r.l = dn_out.last; end
            default: begin r.d[31:0] = eq_out.data; r.k[3:0] = eq_out.keep; r.l = eq_out.last; end
        endcase
        return r;
    endfunction

    function automatic logic ovalid(int m);
        case (m)
            UP: return up_out.valid;
            DN: return dn_out.valid;
            default: return eq_out.valid;
        endcase
    endfunction

    function automatic logic in_rdy(int m);
        case (m)
            UP: return up_in.ready;
            DN: return dn_in.ready;
            default: return eq_in.ready;
        endcase
    endfunction

    task automatic gen(int m);
        int n = (m == UP) ? 2 : (m == DN) ? 8 : 4;
        logic [8:0] lm = 9'((1 << n) - 1);
        in_q.delete();
        for (int p = 0; p < NPKT; p++) begin
            int len = $urandom_range(1, (m == UP) ? 6 : 3);
            for (int b = 0; b < len; b++) begin
                beat_t x;
                x.d = {$urandom, $urandom};
                if ($urandom_range(0, 1) == 1) x.k = 8'($urandom);
                else x.k = 8'((1 << $urandom_range(0, n)) - 1);
                x.k = x.k & lm[7:0];
                x.l = (b == len - 1);
                in_q.push_back(x);
            end
        end
    endtask

    // Packet-level reference: slot filling for upsize, slice splitting with trailing-drop for downsize.
    task automatic build_model(int m);
        beat_t acc = '0;
        int cnt = 0;
        exp_q.delete();
        foreach (in_q[i]) begin
            beat_t b = in_q[i];
            if (m == EQ) begin
                exp_q.push_back(bt(b.d & 64'hFFFF_FFFF, b.k & 8'h0F, b.l));
            end else if (m == UP) begin
                acc.d[cnt*16 +: 16] = b.d[15:0];
                acc.k[cnt*2 +: 2]   = b.k[1:0];
                if (cnt == 3 || b.l) begin
                    acc.l = b.l;
                    exp_q.push_back(acc);
                    acc = '0;
                    cnt = 0;
                end else cnt++;
            end else begin
                int ls = 3;
                if (b.l) begin
                    ls = 0;
                    for (int s = 0; s < 4; s++) if (b.k[s*2 +: 2] != 2'b00) ls = s;
                end
                for (int s = 0; s <= ls; s++)
                    exp_q.push_back(bt({48'h0, b.d[s*16 +: 16]}, {6'h0, b.k[s*2 +: 2]}, b.l && (s == ls)));
            end
        end
    endtask

    task automatic run_random(int m);
        int idx = 0;
        int n = 0;
        logic vin;
        logic stalled = 1'b0;
        beat_t snap = '0;
        gen(m);
        build_model(m);
        while ((idx < in_q.size() || exp_q.size() != 0) && n < 40000) begin
            cyc();
            n++;
            set_rdy(m, 1'($urandom_range(0, 1)));
            vin = (idx < in_q.size()) && ($urandom_range(0, 3) != 0);
            set_in(m, (idx < in_q.size()) ? in_q[idx] : beat_t'('0), vin);
            @(negedge clk);
            if (stalled) chk($sformatf("rnd_stable_m%0d", m), {ovalid(m), get_out(m)}, {1'b1, snap});
            stalled = 1'b0;
            if (ovalid(m)) begin
                if (get_out(m) === get_out(m) && (m == UP ? up_out.ready : m == DN ? dn_out.ready : eq_out.ready)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rnd_extra_m%0d actual=%h required=none", m, get_out(m));
                    end else begin
                        chk($sformatf("rnd_beat_m%0d", m), msk(get_out(m)), msk(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                end else begin
                    stalled = 1'b1;
                    snap = get_out(m);
                end
            end
            if (vin && in_rdy(m)) idx++;
        end
        chk($sformatf("rnd_drain_m%0d", m), 96'(exp_q.size() + (in_q.size() - idx)), 96'd0);
        cyc();
        set_in(m, '0, 1'b0);
        set_rdy(m, 1'b1);
    endtask

    initial begin
        vec_t tbl[8];
        beat_t o;
        logic [63:0] ba, bb, src;

        tbl[0] = '{EQ, bt(64'h04030201, 8'h0F, 1'b1), bt(64'h04030201, 8'h0F, 1'b1)};
        tbl[1] = '{EQ, bt(64'hDDCCBBAA, 8'h05, 1'b0), bt(64'h00CC00AA, 8'h05, 1'b0)};
        tbl[2] = '{EQ, bt(64'h0, 8'h00, 1'b1), bt(64'h0, 8'h00, 1'b1)};
        tbl[3] = '{UP, bt(64'hBBAA, 8'h03, 1'b1), bt(64'hBBAA, 8'h03, 1'b1)};
        tbl[4] = '{UP, bt(64'hBBAA, 8'h02, 1'b1), bt(64'hBB00, 8'h02, 1'b1)};
        tbl[5] = '{DN, bt(64'h8877665544332211, 8'h03, 1'b1), bt(64'h2211, 8'h03, 1'b1)};
        tbl[6] = '{DN, bt(64'h8877665544332211, 8'h00, 1'b1), bt(64'h0, 8'h00, 1'b1)};
        tbl[7] = '{DN, bt(64'h8877665544332211, 8'h01, 1'b1), bt(64'h0011, 8'h01, 1'b1)};

        for (int m = 0; m < 3; m++) begin
            set_in(m, '0, 1'b0);
            set_rdy(m, 1'b1);
        end
        repeat (3) cyc();
        rst_n = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            o = get_out(m);
            chk($sformatf("reset_m%0d", m), {ovalid(m), o.k, o.l, in_rdy(m)}, {1'b0, 8'h00, 1'b0, 1'b1});
        end

        for (int i = 0; i < 8; i++) begin
            cyc();
            set_in(tbl[i].m, tbl[i].b, 1'b1);
            @(negedge clk);
            chk($sformatf("tbl%0d_rdy", i), in_rdy(tbl[i].m), 1'b1);
            cyc();
            set_in(tbl[i].m, '0, 1'b0);
            @(negedge clk);
            chk($sformatf("tbl%0d_out", i), {ovalid(tbl[i].m), msk(get_out(tbl[i].m))}, {1'b1, msk(tbl[i].e)});
            cyc();
            @(negedge clk);
            chk($sformatf("tbl%0d_idle", i), ovalid(tbl[i].m), 1'b0);
        end

        // Upsize, full packet of elements 0..7.
        for (int k = 0; k < 4; k++) begin
            cyc();
            set_in(UP, bt({48'h0, 8'(2*k+1), 8'(2*k)}, 8'h03, k == 3), 1'b1);
            @(negedge clk);
            chk("up_full_wait", {ovalid(UP), in_rdy(UP)}, 2'b01);
        end
        cyc();
        set_in(UP, '0, 1'b0);
        @(negedge clk);
        chk("up_full_out", {ovalid(UP), msk(get_out(UP))}, {1'b1, bt(64'h0706050403020100, 8'hFF, 1'b1)});

        // Upsize early last, next packet back-to-back must land in slot 0.
        for (int k = 0; k < 4; k++) begin
            cyc();
            set_in(UP, bt({48'h0, 8'(8'h11 + 2*k), 8'(8'h10 + 2*k)}, 8'h03, k >= 2), 1'b1);
            @(negedge clk);
            if (k < 3) chk("up_early_wait", ovalid(UP), 1'b0);
            else chk("up_early_out", {ovalid(UP), msk(get_out(UP))}, {1'b1, bt(64'h151413121110, 8'h3F, 1'b1)});
        end
        cyc();
        set_in(UP, '0, 1'b0);
        @(negedge clk);
        chk("up_next_slot0", {ovalid(UP), msk(get_out(UP))}, {1'b1, bt(64'h1716, 8'h03, 1'b1)});

        // Downsize, last beat with only the first two slices populated.
        cyc();
        set_in(DN, bt(64'h8877665544332211, 8'h0F, 1'b1), 1'b1);
        @(negedge clk);
        chk("dn_last_rdy", in_rdy(DN), 1'b1);
        cyc();
        set_in(DN, '0, 1'b0);
        @(negedge clk);
        chk("dn_last_s0", {ovalid(DN), msk(get_out(DN)), in_rdy(DN)}, {1'b1, bt(64'h2211, 8'h03, 1'b0), 1'b0});
        cyc();
        @(negedge clk);
        chk("dn_last_s1", {ovalid(DN), msk(get_out(DN)), in_rdy(DN)}, {1'b1, bt(64'h4433, 8'h03, 1'b1), 1'b1});
        cyc();
        @(negedge clk);
        chk("dn_last_done", ovalid(DN), 1'b0);

        // Downsize, two full non-last beats offered back-to-back: one accept per 4 cycles.
        ba = 64'hA7A6A5A4A3A2A1A0;
        bb = 64'hB7B6B5B4B3B2B1B0;
        cyc();
        set_in(DN, bt(ba, 8'hFF, 1'b0), 1'b1);
        cyc();
        set_in(DN, bt(bb, 8'hFF, 1'b0), 1'b1);
        for (int i = 0; i < 8; i++) begin
            src = (i < 4) ? ba : bb;
            @(negedge clk);
            chk($sformatf("dn_full_%0d", i), {ovalid(DN), msk(get_out(DN)), in_rdy(DN)},
                {1'b1, bt({48'h0, src[(i%4)*16 +: 16]}, 8'h03, 1'b0), (i % 4) == 3});
            cyc();
            if (i == 3) set_in(DN, '0, 1'b0);
        end
        @(negedge clk);
        chk("dn_full_idle", ovalid(DN), 1'b0);

        // Reset while upsize holds two slots and a completing beat is offered.
        cyc();
        set_in(UP, bt(64'h3130, 8'h03, 1'b0), 1'b1);
        cyc();
        set_in(UP, bt(64'h3332, 8'h03, 1'b0), 1'b1);
        cyc();
        set_in(UP, bt(64'h3534, 8'h03, 1'b1), 1'b1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        set_in(UP, '0, 1'b0);
        @(negedge clk);
        o = get_out(UP);
        chk("rst_mid", {ovalid(UP), o.k, o.l, in_rdy(UP)}, {1'b0, 8'h00, 1'b0, 1'b1});
        cyc();
        set_in(UP, bt(64'h4140, 8'h03, 1'b1), 1'b1);
        cyc();
        set_in(UP, '0, 1'b0);
        @(negedge clk);
        chk("rst_realign", {ovalid(UP), msk(get_out(UP))}, {1'b1, bt(64'h4140, 8'h03, 1'b1)});
        cyc();

        run_random(UP);
        run_random(DN);
        run_random(EQ);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
